// File: rtl/ram_io_responder_if.sv
// rtl/ram_io_responder_if.sv - byte-wide RAM bus between the memory accesser and its responder
interface ram_io_responder_if;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din;
   logic        cpu_rdy;

   modport master (output mem_a, output mem_wr, output mem_dout, input mem_din, input cpu_rdy);
   modport slave  (input mem_a, input mem_wr, input mem_dout, output mem_din, output cpu_rdy);
endinterface

// File: rtl/ram_io_responder.sv
// rtl/ram_io_responder.sv - block RAM plus I/O page (TX FIFO, RX byte, status, halt) and core stall
// Optional cycle counter with coherent snapshot: define CYCLE_COUNTER_EN.
module ram_io_responder #(
   parameter int RAM_AW      = 17,
   parameter int TX_DEPTH_LG = 4
) (
   input  logic                clk,
   input  logic                rst,
   ram_io_responder_if.slave   bus,
   output logic [7:0]          tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   output logic                rx_ready,
   output logic                halt
);
   localparam int TX_DEPTH = 1 << TX_DEPTH_LG;

   logic [7:0]              ram [2**RAM_AW];
   logic [7:0]              ram_q;
   logic [7:0]              tx_mem [TX_DEPTH];
   logic [TX_DEPTH_LG-1:0]  wr_ptr_q, rd_ptr_q;
   logic [TX_DEPTH_LG:0]    tx_cnt_q, tx_cnt_d;
   logic                    rx_full_q;
   logic [7:0]              rx_q;
   logic                    halt_q;
   logic                    sel_ram_q;
   logic [7:0]              io_q, io_d;
`ifdef CYCLE_COUNTER_EN
   logic [31:0]             cyc_q, snap_q;
`endif

   logic [RAM_AW-1:0] ram_idx;
   logic              io_sel, io_rd, tx_wr_req, tx_full, push, pop, rx_read, capture;
   logic [3:0]        off;
   logic              unused_bits;

   assign ram_idx     = bus.mem_a[RAM_AW-1:0];
   assign io_sel      = bus.mem_a[17];
   assign off         = bus.mem_a[3:0];
   assign unused_bits = ^bus.mem_a;
   assign io_rd       = !bus.mem_wr && io_sel;
   assign tx_wr_req   = bus.mem_wr && io_sel && (off == 4'h0);
   // Full comes from the registered count, so a pop cannot admit a push in the same cycle.
   assign tx_full     = (tx_cnt_q == TX_DEPTH[TX_DEPTH_LG:0]);
   assign push        = tx_wr_req && !tx_full;
   assign pop         = tx_valid && tx_ready;
   assign bus.cpu_rdy = !(tx_wr_req && tx_full);
   assign rx_read     = io_rd && (off == 4'h0) && bus.cpu_rdy;
   assign capture     = rx_valid && !rx_full_q;

   assign tx_valid    = (tx_cnt_q != '0);
   assign tx_data     = tx_mem[rd_ptr_q];
   assign rx_ready    = !rx_full_q;
   assign halt        = halt_q;
   assign bus.mem_din = sel_ram_q ? ram_q : io_q;

   always_comb begin
      tx_cnt_d = tx_cnt_q;
      if (push && !pop)
         tx_cnt_d = tx_cnt_q + 1'b1;
      else if (pop && !push)
         tx_cnt_d = tx_cnt_q - 1'b1;
   end

   always_comb begin
      io_d = 8'h00;
      if (io_rd) begin
         case (off)
            4'h0:    io_d = rx_full_q ? rx_q : 8'h00;
            4'h4:    io_d = {6'b0, rx_full_q, tx_full};
`ifdef CYCLE_COUNTER_EN
            4'h8:    io_d = cyc_q[7:0];
            4'h9:    io_d = snap_q[15:8];
            4'hA:    io_d = snap_q[23:16];
            4'hB:    io_d = snap_q[31:24];
`endif
            default: io_d = 8'h00;
         endcase
      end
   end

   // RAM has no reset; the read port returns the pre-write byte on a same-address write.
   always_ff @(posedge clk) begin
      if (bus.mem_wr && !io_sel)
         ram[ram_idx] <= bus.mem_dout;
      ram_q <= ram[ram_idx];
   end

   always_ff @(posedge clk) begin
      if (push)
         tx_mem[wr_ptr_q] <= bus.mem_dout;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         tx_cnt_q  <= '0;
         rx_full_q <= 1'b0;
         rx_q      <= 8'h00;
         halt_q    <= 1'b0;
         sel_ram_q <= 1'b0;
         io_q      <= 8'h00;
`ifdef CYCLE_COUNTER_EN
         cyc_q     <= 32'h0;
         snap_q    <= 32'h0;
`endif
      end else begin
         if (push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         tx_cnt_q <= tx_cnt_d;
         if (capture) begin
            rx_q      <= rx_data;
            rx_full_q <= 1'b1;
         end else if (rx_read) begin
            rx_full_q <= 1'b0;
         end
         if (bus.mem_wr && io_sel && (off == 4'h4))
            halt_q <= 1'b1;
         sel_ram_q <= !io_sel;
         io_q      <= io_d;
`ifdef CYCLE_COUNTER_EN
         cyc_q <= cyc_q + 32'h1;
         if (io_rd && (off == 4'h8) && bus.cpu_rdy)
            snap_q <= cyc_q;
`endif
      end
   end
endmodule

// File: tb/tb_ram_io_responder.sv
// tb/tb_ram_io_responder.sv - directed self-checking bench for ram_io_responder
module tb_ram_io_responder;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       rx_ready;
   logic       halt;
   int         n_checks = 0;
   int         n_fails = 0;

   ram_io_responder_if bus ();

   ram_io_responder dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .halt     (halt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [31:0] a, input logic wr, input logic [7:0] d);
      bus.mem_a    = a;
      bus.mem_wr   = wr;
      bus.mem_dout = d;
      @(negedge clk);
   endtask

   initial begin
      bus.mem_a    = 32'h0;
      bus.mem_wr   = 1'b0;
      bus.mem_dout = 8'h00;
      @(negedge clk);
      @(negedge clk);
      check("rst_mem_din", {24'h0, bus.mem_din}, 32'h00);
      check("rst_cpu_rdy", {31'h0, bus.cpu_rdy}, 32'h1);
      check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
      check("rst_halt", {31'h0, halt}, 32'h0);
      rst = 1'b0;

      // RAM write then read
      step(32'h0001_0010, 1'b1, 8'h5A);
      step(32'h0001_0010, 1'b0, 8'h00);
      check("ram_rd", {24'h0, bus.mem_din}, 32'h5A);
      // Read during write returns old byte; address wraps modulo RAM size
      step(32'h0000_0020, 1'b1, 8'h11);
      step(32'h0000_0020, 1'b1, 8'h22);
      check("ram_rdw_old", {24'h0, bus.mem_din}, 32'h11);
      step(32'h0004_0020, 1'b0, 8'h00);
      check("ram_rd_new_wrap", {24'h0, bus.mem_din}, 32'h22);

      // TX fill and stall
      tx_ready = 1'b0;
      for (int i = 0; i < 16; i++) step(32'h0003_0000, 1'b1, 8'h40 + 8'(i));
      check("tx_valid_full", {31'h0, tx_valid}, 32'h1);
      check("tx_head", {24'h0, tx_data}, 32'h40);
      bus.mem_dout = 8'h99;
      #1;
      check("stall_comb", {31'h0, bus.cpu_rdy}, 32'h0);
      @(negedge clk);
      check("stall_held", {31'h0, bus.cpu_rdy}, 32'h0);
      check("stall_head", {24'h0, tx_data}, 32'h40);
      tx_ready = 1'b1;
      @(negedge clk);
      check("pop_head", {24'h0, tx_data}, 32'h41);
      check("stall_release", {31'h0, bus.cpu_rdy}, 32'h1);
      tx_ready = 1'b0;
      @(negedge clk);
      bus.mem_a  = 32'h0;
      bus.mem_wr = 1'b0;
      tx_ready   = 1'b1;
      for (int i = 1; i < 16; i++) begin
         check("drain", {24'h0, tx_data}, 32'h40 + 32'(i));
         @(negedge clk);
      end
      check("tail_17th", {24'h0, tx_data}, 32'h99);
      check("tail_valid", {31'h0, tx_valid}, 32'h1);
      @(negedge clk);
      check("tx_empty", {31'h0, tx_valid}, 32'h0);
      tx_ready = 1'b0;

      // RX holding register
      rx_valid = 1'b1;
      rx_data  = 8'hC3;
      @(negedge clk);
      check("rx_full", {31'h0, rx_ready}, 32'h0);
      rx_valid = 1'b0;
      step(32'h0003_0004, 1'b0, 8'h00);
      check("status", {24'h0, bus.mem_din}, 32'h02);
      step(32'h0003_0000, 1'b0, 8'h00);
      check("rx_byte", {24'h0, bus.mem_din}, 32'hC3);
      check("rx_cleared", {31'h0, rx_ready}, 32'h1);
      step(32'h0003_0000, 1'b0, 8'h00);
      check("rx_empty_rd", {24'h0, bus.mem_din}, 32'h00);
      step(32'h0003_0003, 1'b0, 8'h00);
      check("unmapped_rd", {24'h0, bus.mem_din}, 32'h00);

      // Halt sticky, then reset during a TX stall
      step(32'h0003_0004, 1'b1, 8'h00);
      check("halt_set", {31'h0, halt}, 32'h1);
      step(32'h0000_0000, 1'b0, 8'h00);
      check("halt_sticky", {31'h0, halt}, 32'h1);
      for (int i = 0; i < 16; i++) step(32'h0003_0000, 1'b1, 8'(i));
      bus.mem_dout = 8'h77;
      #1;
      check("stall2", {31'h0, bus.cpu_rdy}, 32'h0);
      rst = 1'b1;
      #1;
      check("arst_cpu_rdy", {31'h0, bus.cpu_rdy}, 32'h1);
      check("arst_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("arst_halt", {31'h0, halt}, 32'h0);
      check("arst_mem_din", {24'h0, bus.mem_din}, 32'h00);
      bus.mem_a  = 32'h0;
      bus.mem_wr = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Counter snapshot: read of 0x8 on the 256th edge after release sees count 0xFF
      for (int i = 0; i < 255; i++) step(32'h0000_0000, 1'b0, 8'h00);
      step(32'h0003_0008, 1'b0, 8'h00);
`ifdef CYCLE_COUNTER_EN
      check("cnt_b0", {24'h0, bus.mem_din}, 32'hFF);
`else
      check("cnt_b0", {24'h0, bus.mem_din}, 32'h00);
`endif
      step(32'h0003_0009, 1'b0, 8'h00);
      check("cnt_b1", {24'h0, bus.mem_din}, 32'h00);
      step(32'h0003_000A, 1'b0, 8'h00);
      check("cnt_b2", {24'h0, bus.mem_din}, 32'h00);
      step(32'h0003_000B, 1'b0, 8'h00);
      check("cnt_b3", {24'h0, bus.mem_din}, 32'h00);
      step(32'h0003_0008, 1'b0, 8'h00);
      step(32'h0003_0009, 1'b0, 8'h00);
`ifdef CYCLE_COUNTER_EN
      check("cnt2_b1", {24'h0, bus.mem_din}, 32'h01);
`else
      check("cnt2_b1", {24'h0, bus.mem_din}, 32'h00);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
